// File: rtl/fft_magnitude_stream.sv
// FFT bin magnitude estimator (max + 3/8 min) feeding a 512-entry visualizer; `FFT_MAG_SMOOTH_EN adds per-bin smoothing.
// Latency 3 cycles (5 with FFT_MAG_SMOOTH_EN); no backpressure, exactly one output per accepted bin.
module fft_magnitude_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_fft_re,
    input  logic [15:0] i_fft_im,
    input  logic        i_fft_valid,
    input  logic        i_fft_sop,
    output logic [8:0]  o_fft_addr,
    output logic [23:0] o_fft_mag,
    output logic        o_fft_valid,
    output logic        o_frame_done,
    output logic        o_frame_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_err;
    logic [8:0]  r_cnt;
    logic [8:0]  w_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN is sticky; only reset brings the block back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE && i_fft_valid && i_fft_sop) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_accept = i_fft_valid && ((r_state == ST_RUN) || i_fft_sop);
        w_err    = i_fft_valid && i_fft_sop && (r_state == ST_RUN) && (r_cnt != 9'd0);
    end

    assign w_bin = i_fft_sop ? 9'd0 : r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 9'd0;
        end else if (w_accept) begin
            r_cnt <= w_bin + 9'd1;
        end
    end

    // 17-bit absolute values so that |-32768| stays 32768
    logic [16:0] w_re_ext;
    logic [16:0] w_im_ext;
    logic [16:0] w_re_abs;
    logic [16:0] w_im_abs;

    assign w_re_ext = {i_fft_re[15], i_fft_re};
    assign w_im_ext = {i_fft_im[15], i_fft_im};
    assign w_re_abs = i_fft_re[15] ? (17'd0 - w_re_ext) : w_re_ext;
    assign w_im_abs = i_fft_im[15] ? (17'd0 - w_im_ext) : w_im_ext;

    logic        r_s1_vld;
    logic [8:0]  r_s1_addr;
    logic [16:0] r_s1_re_abs;
    logic [16:0] r_s1_im_abs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= 9'd0;
            r_s1_re_abs <= 17'd0;
            r_s1_im_abs <= 17'd0;
        end else begin
            r_s1_vld    <= w_accept;
            r_s1_addr   <= w_bin;
            r_s1_re_abs <= w_re_abs;
            r_s1_im_abs <= w_im_abs;
        end
    end

    logic [16:0] w_max;
    logic [16:0] w_min;
    logic [16:0] w_mag;

    assign w_max = (r_s1_re_abs >= r_s1_im_abs) ? r_s1_re_abs : r_s1_im_abs;
    assign w_min = (r_s1_re_abs >= r_s1_im_abs) ? r_s1_im_abs : r_s1_re_abs;
    // Peak is 45056, so bit 16 of the sum is always zero
    assign w_mag = w_max + (w_min >> 2) + (w_min >> 3);

    logic        r_s2_vld;
    logic [8:0]  r_s2_addr;
    logic [16:0] r_s2_mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_addr <= 9'd0;
            r_s2_mag  <= 17'd0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_addr <= r_s1_addr;
            r_s2_mag  <= w_mag;
        end
    end

    logic        w_out_vld;
    logic [8:0]  w_out_addr;
    logic [23:0] w_out_mag;

`ifdef FFT_MAG_SMOOTH_EN
    // Init tag rides with each sample: first frame after reset or restart seeds the accumulators
    logic        r_init;
    logic        w_init_tag;
    logic        r_s1_init;
    logic        r_s2_init;

    assign w_init_tag = r_init | w_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init    <= 1'b1;
            r_s1_init <= 1'b0;
            r_s2_init <= 1'b0;
        end else begin
            if (w_accept) begin
                r_init <= (w_bin == 9'd511) ? 1'b0 : w_init_tag;
            end
            r_s1_init <= w_init_tag;
            r_s2_init <= r_s1_init;
        end
    end

    logic [23:0] r_ram [0:511];
    logic [23:0] r_sa_rd;
    logic        r_sa_vld;
    logic [8:0]  r_sa_addr;
    logic [16:0] r_sa_mag;
    logic        r_sa_init;
    logic        r_sb_vld;
    logic [8:0]  r_sb_addr;
    logic [23:0] r_sb_acc;
    logic [23:0] w_acc_old;
    logic [23:0] w_acc_new;
    logic        w_ram_we;

    // The only read-after-write hazard is the sample one stage ahead, which now sits in sB
    assign w_acc_old = (r_sb_vld && (r_sb_addr == r_sa_addr)) ? r_sb_acc : r_sa_rd;
    assign w_acc_new = r_sa_init ? {4'd0, r_sa_mag, 3'd0}
                                 : (w_acc_old - (w_acc_old >> 3) + {7'd0, r_sa_mag});
    assign w_ram_we  = rst_n && r_sa_vld;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_sa_addr] <= w_acc_new;
        end
        r_sa_rd <= r_ram[r_s2_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa_vld  <= 1'b0;
            r_sa_addr <= 9'd0;
            r_sa_mag  <= 17'd0;
            r_sa_init <= 1'b0;
            r_sb_vld  <= 1'b0;
            r_sb_addr <= 9'd0;
            r_sb_acc  <= 24'd0;
        end else begin
            r_sa_vld  <= r_s2_vld;
            r_sa_addr <= r_s2_addr;
            r_sa_mag  <= r_s2_mag;
            r_sa_init <= r_s2_init;
            r_sb_vld  <= r_sa_vld;
            r_sb_addr <= r_sa_addr;
            r_sb_acc  <= w_acc_new;
        end
    end

    assign w_out_vld  = r_sb_vld;
    assign w_out_addr = r_sb_addr;
    assign w_out_mag  = r_sb_acc;
`else
    assign w_out_vld  = r_s2_vld;
    assign w_out_addr = r_s2_addr;
    assign w_out_mag  = {7'd0, r_s2_mag};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_fft_valid  <= 1'b0;
            o_fft_addr   <= 9'd0;
            o_fft_mag    <= 24'd0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_fft_valid  <= w_out_vld;
            o_fft_addr   <= w_out_addr;
            o_fft_mag    <= w_out_mag;
            o_frame_done <= w_out_vld && (w_out_addr == 9'd511);
            o_frame_err  <= w_err;
        end
    end

endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Scoreboard bench for fft_magnitude_stream: random bins against an arithmetic reference model.
module tb_fft_magnitude_stream;

`ifdef FFT_MAG_SMOOTH_EN
    localparam int LAT  = 5;
    localparam int GAIN = 8;
`else
    localparam int LAT  = 3;
    localparam int GAIN = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_fft_re;
    logic [15:0] i_fft_im;
    logic        i_fft_valid;
    logic        i_fft_sop;
    logic [8:0]  o_fft_addr;
    logic [23:0] o_fft_mag;
    logic        o_fft_valid;
    logic        o_frame_done;
    logic        o_frame_err;

    fft_magnitude_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fft_re     (i_fft_re),
        .i_fft_im     (i_fft_im),
        .i_fft_valid  (i_fft_valid),
        .i_fft_sop    (i_fft_sop),
        .o_fft_addr   (o_fft_addr),
        .o_fft_mag    (o_fft_mag),
        .o_fft_valid  (o_fft_valid),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int mag;
        int issue;
    } exp_t;

    exp_t q[$];
    int   err_q[$];
    int   bin5_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int n_done = 0;
    int n_err  = 0;
    int last_mag  = -1;
    int last_addr = -1;
    bit mon_en = 1'b0;

    // Reference model state
    bit m_run  = 1'b0;
    int m_next = 0;
    bit m_init = 1'b1;
    int m_errs = 0;
    int m_acc[512];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mag16(input int re, input int im);
        int a;
        int b;
        int mx;
        int mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + (mn / 4) + (mn / 8);
    endfunction

    function automatic int rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 7) == 0) v = 16'h8000;
        return int'($signed(v));
    endfunction

    task automatic send(input bit sop, input int re, input int im);
        int   bin;
        int   m;
        exp_t e;
        @(posedge clk);
        #1;
        i_fft_valid = 1'b1;
        i_fft_sop   = sop;
        i_fft_re    = re[15:0];
        i_fft_im    = im[15:0];
        if (m_run || sop) begin
            if (sop && m_run && m_next != 0) begin
                err_q.push_back(cyc);
                m_errs++;
                m_init = 1'b1;
            end
            m_run = 1'b1;
            bin   = sop ? 0 : m_next;
            m     = mag16(re, im);
`ifdef FFT_MAG_SMOOTH_EN
            if (m_init) m_acc[bin] = m * 8;
            else        m_acc[bin] = m_acc[bin] - m_acc[bin] / 8 + m;
            if (bin == 511) m_init = 1'b0;
            m = m_acc[bin];
`endif
            e.addr  = bin;
            e.mag   = m;
            e.issue = cyc;
            q.push_back(e);
            m_next = (bin + 1) % 512;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_fft_valid = 1'b0;
            i_fft_sop   = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending after %0d cycles, expected 0", q.size(), t);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        i_fft_valid = 1'b0;
        i_fft_sop   = 1'b0;
        // Samples too young to leave the pipeline before the reset edge are lost
        while (q.size() > 0 && (cyc - q[$].issue) < LAT) void'(q.pop_back());
        while (err_q.size() > 0 && (cyc - err_q[$]) < 1) void'(err_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(o_fft_valid), 0);
        check("rst_addr", int'(o_fft_addr), 0);
        check("rst_mag", int'(o_fft_mag), 0);
        check("rst_done", int'(o_frame_done), 0);
        check("rst_err", int'(o_frame_err), 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_run  = 1'b0;
        m_next = 0;
        m_init = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_fft_valid) begin
                n_out++;
                last_addr = int'(o_fft_addr);
                last_mag  = int'(o_fft_mag);
                if (o_fft_addr == 9'd5) bin5_q.push_back(int'(o_fft_mag));
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got addr=%0d mag=%0d, expected no output", o_fft_addr, o_fft_mag);
                end else begin
                    mon_e = q.pop_front();
                    check("addr", int'(o_fft_addr), mon_e.addr);
                    check("mag", int'(o_fft_mag), mon_e.mag);
                    check("latency", cyc - mon_e.issue, LAT);
                    check("done", int'(o_frame_done), (mon_e.addr == 511) ? 1 : 0);
                end
            end else if (o_frame_done) begin
                checks++;
                errors++;
                $display("FAIL done_without_valid: got o_frame_done=1, expected 0");
            end
            if (o_frame_done) n_done++;
            if (o_frame_err) begin
                n_err++;
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got o_frame_err=1, expected 0");
                end else begin
                    check("err_timing", cyc - err_q.pop_front(), 1);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, CHECKS %0d", checks);
        $fatal(1);
    end

    initial begin
        int o0;
        int d0;
        int e0;
        rst_n       = 1'b0;
        i_fft_valid = 1'b0;
        i_fft_sop   = 1'b0;
        i_fft_re    = 16'd0;
        i_fft_im    = 16'd0;
        do_reset();
        mon_en = 1'b1;

        // Directed magnitude values
        send(1'b1, 3000, -4000);
        drain();
        check("mag_3000_m4000", last_mag, 5125 * GAIN);
        check("addr_first", last_addr, 0);
        do_reset();
        send(1'b1, -32768, -32768);
        drain();
        check("mag_full_scale", last_mag, 45056 * GAIN);
        send(1'b0, 0, 0);
        drain();
        check("mag_zero", last_mag, 0);
        check("addr_zero_bin", last_addr, 1);

        // Full frame with gaps, then free-running wrap
        do_reset();
        d0 = n_done;
        send(1'b1, rnd16(), rnd16());
        for (int i = 1; i < 512; i++) begin
            idle($urandom_range(1, 3));
            send(1'b0, rnd16(), rnd16());
        end
        drain();
        check("frame_done_count", n_done - d0, 1);
        check("frame_last_addr", last_addr, 511);
        send(1'b0, rnd16(), rnd16());
        drain();
        check("wrap_addr", last_addr, 0);

        // No output before sop after reset
        do_reset();
        o0 = n_out;
        for (int i = 0; i < 100; i++) send(1'b0, rnd16(), rnd16());
        idle(LAT + 3);
        check("idle_no_output", n_out - o0, 0);
        send(1'b1, rnd16(), rnd16());
        drain();
        check("first_after_idle", last_addr, 0);

        // Early sop restarts frame; in-flight bins keep their addresses
        e0 = n_err;
        for (int i = 1; i < 100; i++) send(1'b0, rnd16(), rnd16());
        send(1'b1, rnd16(), rnd16());
        for (int i = 0; i < 20; i++) send(1'b0, rnd16(), rnd16());
        drain();
        check("early_sop_err_count", n_err - e0, 1);
        check("after_restart_addr", last_addr, 20);

        // Reset in the middle of back-to-back traffic
        for (int i = 0; i < 10; i++) send(1'b0, rnd16(), rnd16());
        do_reset();
        o0 = n_out;
        idle(LAT + 5);
        check("no_residual_valid", n_out - o0, 0);

        // Random traffic with occasional sop
        do_reset();
        e0 = n_err;
        m_errs = 0;
        send(1'b1, rnd16(), rnd16());
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send(($urandom_range(0, 199) == 0), rnd16(), rnd16());
        end
        drain();
        check("random_err_count", n_err - e0, m_errs);

`ifdef FFT_MAG_SMOOTH_EN
        // Bin 5 smoothing across three frames
        do_reset();
        bin5_q.delete();
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 512; b++) begin
                if (b == 5) send(1'b0, (f == 0) ? 1000 : 0, 0);
                else        send((f == 0 && b == 0), rnd16(), rnd16());
            end
        end
        drain();
        check("bin5_count", bin5_q.size(), 3);
        if (bin5_q.size() == 3) begin
            check("bin5_frame1", bin5_q[0], 8000);
            check("bin5_frame2", bin5_q[1], 7000);
            check("bin5_frame3", bin5_q[2], 6125);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
